// File: rtl/controle_varredura_display.sv
`default_nettype none
// ============================================================================
//  Module      : controle_varredura_display
//  Description : Scan controller for the two-digit scoreboard display.
//                Latches the BCD score once per frame, drives the nibble
//                multiplexer select (escolha) and the active-low digit
//                enables (anodo), with a blanking gap before each digit.
//
//  Ports       : clk        - system clock, rising edge
//                reset      - synchronous active-high reset
//                placar     - BCD score, [3:0] units, [7:4] tens
//                habilita   - scan enable, 0 = idle/dark
//                apaga_zero - blank tens digit when it is zero
//                N          - latched score for the multiplexer
//                escolha    - mux select, 0 = units, 1 = tens
//                anodo      - active-low enables, [0] units, [1] tens
//                quadro     - one-cycle pulse on the first cycle of a frame
//
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_varredura_display #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] placar,
    input  logic       habilita,
    input  logic       apaga_zero,
    output logic [7:0] N,
    output logic       escolha,
    output logic [1:0] anodo,
    output logic       quadro
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] C_SLOT_LAST  = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BLANK_U = 3'd1,
        S_SHOW_U  = 3'd2,
        S_BLANK_T = 3'd3,
        S_SHOW_T  = 3'd4
    } state_t;

    state_t        r_state_q, w_state_d;
    logic [CW-1:0] r_cnt_q,   w_cnt_d;
    logic [7:0]    r_n_q,     w_n_d;
    logic          r_z_q,     w_z_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_n_q     <= 8'h00;
            r_z_q     <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_n_q     <= w_n_d;
            r_z_q     <= w_z_d;
        end
    end

    // Next-state logic. The counter runs straight through a BLANK/SHOW pair
    // and is only cleared on entry to a BLANK state (a new slot).
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q + 1'b1;
        w_n_d     = r_n_q;
        w_z_d     = r_z_q;

        if (!habilita) begin
            w_state_d = S_IDLE;
            w_cnt_d   = '0;
        end else begin
            case (r_state_q)
                S_IDLE: begin
                    w_state_d = S_BLANK_U;
                    w_cnt_d   = '0;
                    w_n_d     = placar;
                    w_z_d     = apaga_zero;
                end
                S_BLANK_U: begin
                    if (r_cnt_q == C_BLANK_LAST) w_state_d = S_SHOW_U;
                end
                S_SHOW_U: begin
                    if (r_cnt_q == C_SLOT_LAST) begin
                        w_state_d = S_BLANK_T;
                        w_cnt_d   = '0;
                    end
                end
                S_BLANK_T: begin
                    if (r_cnt_q == C_BLANK_LAST) w_state_d = S_SHOW_T;
                end
                S_SHOW_T: begin
                    if (r_cnt_q == C_SLOT_LAST) begin
                        // Frame boundary: take one coherent sample of the score
                        w_state_d = S_BLANK_U;
                        w_cnt_d   = '0;
                        w_n_d     = placar;
                        w_z_d     = apaga_zero;
                    end
                end
                default: begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    // Moore outputs: registered state, counter and frame latch only.
    always_comb begin
        anodo   = 2'b11;
        escolha = 1'b0;
        quadro  = 1'b0;
        case (r_state_q)
            S_BLANK_U: quadro = (r_cnt_q == '0);
            S_SHOW_U:  anodo  = 2'b10;
            S_BLANK_T: escolha = 1'b1;
            S_SHOW_T: begin
                escolha = 1'b1;
                anodo   = (r_z_q && (r_n_q[7:4] == 4'h0)) ? 2'b11 : 2'b01;
            end
            default: ;
        endcase
    end

    assign N = r_n_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_varredura_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controle_varredura_display
//  Description : Self-checking bench for controle_varredura_display with
//                DIV = 8, BLANK = 2. A frame-position model predicts every
//                output each cycle; directed scenarios are followed by a
//                randomized run with display invariants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_varredura_display;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 2 * DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] placar;
    logic       habilita;
    logic       apaga_zero;
    logic [7:0] N;
    logic       escolha;
    logic [1:0] anodo;
    logic       quadro;

    controle_varredura_display #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .reset      (reset),
        .placar     (placar),
        .habilita   (habilita),
        .apaga_zero (apaga_zero),
        .N          (N),
        .escolha    (escolha),
        .anodo      (anodo),
        .quadro     (quadro)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: running flag, position within the frame, latched data.
    bit       m_en  = 0;
    int       m_pos = 0;
    bit [7:0] m_n   = 8'h00;
    bit       m_z   = 0;

    // Invariant tracking
    bit       inv_on    = 0;
    logic     prev_esc  = 1'b0;
    int       cyc       = 0;
    int       last_q    = -1;

    task automatic model_edge();
        if (reset) begin
            m_en = 0; m_pos = 0; m_n = 8'h00; m_z = 0;
        end else if (!habilita) begin
            m_en = 0; m_pos = 0;
        end else if (!m_en) begin
            m_en = 1; m_pos = 0; m_n = placar; m_z = apaga_zero;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            if (m_pos == 0) begin
                m_n = placar; m_z = apaga_zero;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [1:0] e_a;
        logic       e_e, e_q;
        int         slot, off;
        e_a = 2'b11; e_e = 1'b0; e_q = 1'b0;
        if (m_en) begin
            slot = m_pos / DIV;
            off  = m_pos % DIV;
            e_e  = (slot == 1);
            e_q  = (m_pos == 0);
            if (off >= BLANK) begin
                if (slot == 0)                       e_a = 2'b10;
                else if (m_z && m_n[7:4] == 4'h0)    e_a = 2'b11;
                else                                 e_a = 2'b01;
            end
        end
        n_cmp++;
        assert (anodo === e_a) else begin
            n_err++; $error("FAIL %s anodo: got %b expected %b (pos %0d)", tag, anodo, e_a, m_pos);
        end
        n_cmp++;
        assert (escolha === e_e) else begin
            n_err++; $error("FAIL %s escolha: got %b expected %b (pos %0d)", tag, escolha, e_e, m_pos);
        end
        n_cmp++;
        assert (quadro === e_q) else begin
            n_err++; $error("FAIL %s quadro: got %b expected %b (pos %0d)", tag, quadro, e_q, m_pos);
        end
        n_cmp++;
        assert (N === m_n) else begin
            n_err++; $error("FAIL %s N: got %h expected %h (pos %0d)", tag, N, m_n, m_pos);
        end
    endtask

    task automatic check_invariants();
        n_cmp++;
        assert (anodo !== 2'b00) else begin
            n_err++; $error("FAIL inv_anodo: got %b expected not 00", anodo);
        end
        if (escolha !== prev_esc) begin
            n_cmp++;
            assert (anodo === 2'b11) else begin
                n_err++; $error("FAIL inv_escolha: anodo %b at escolha toggle expected 11", anodo);
            end
        end
        if (reset || !habilita) last_q = -1;
        if (quadro === 1'b1) begin
            if (last_q >= 0) begin
                n_cmp++;
                assert (cyc - last_q >= FRAME) else begin
                    n_err++; $error("FAIL inv_quadro: spacing %0d expected >= %0d", cyc - last_q, FRAME);
                end
            end
            last_q = cyc;
        end
        prev_esc = escolha;
    endtask

    // One clock: inputs already driven, sample edge, update model, check.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_outputs(tag);
        if (inv_on) check_invariants();
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Advance until the model reaches frame position p, bounded.
    task automatic run_to(input int p, input string tag);
        int guard;
        guard = 0;
        while (!(m_en && m_pos == p) && guard < 4 * FRAME) begin
            tick(tag);
            guard++;
        end
        n_cmp++;
        assert (m_en && m_pos == p) else begin
            n_err++; $error("FAIL %s timeout: pos %0d expected %0d", tag, m_pos, p);
        end
    endtask

    initial begin
        reset = 1'b1; habilita = 1'b0; placar = 8'h00; apaga_zero = 1'b0;
        #2;
        run(2, "reset");
        reset = 1'b0;
        run(10, "idle_hold");

        // Normal scan of 0x47, two full frames
        placar = 8'h47; habilita = 1'b1;
        run(2 * FRAME, "scan47");

        // Frame coherence: change score in SHOW_U, tens slot keeps old sample
        run_to(4, "coh_seek");
        placar = 8'h52;
        run_to(DIV + BLANK + 1, "coh_tens");
        n_cmp++;
        assert (N === 8'h47 && anodo === 2'b01) else begin
            n_err++; $error("FAIL coh_tens: got N %h anodo %b expected 47 01", N, anodo);
        end
        run_to(0, "coh_next");
        n_cmp++;
        assert (N === 8'h52 && quadro === 1'b1) else begin
            n_err++; $error("FAIL coh_next: got N %h quadro %b expected 52 1", N, quadro);
        end

        // Leading-zero blanking, then normal tens display
        placar = 8'h05; apaga_zero = 1'b1;
        run_to(FRAME - 1, "lz_seek");
        run(FRAME, "lz_on");
        apaga_zero = 1'b0;
        run(FRAME, "lz_off");

        // Abort via habilita at SHOW_T cnt = 4, then restart
        run_to(DIV + 4, "abort_seek");
        habilita = 1'b0;
        tick("abort_hab");
        n_cmp++;
        assert (anodo === 2'b11 && escolha === 1'b0 && N === 8'h05) else begin
            n_err++; $error("FAIL abort_hab: got %b/%b/%h expected 11/0/05", anodo, escolha, N);
        end
        habilita = 1'b1;
        tick("restart_hab");
        n_cmp++;
        assert (quadro === 1'b1) else begin
            n_err++; $error("FAIL restart_hab quadro: got %b expected 1", quadro);
        end
        run(FRAME, "restart_hab_run");

        // Abort via reset at SHOW_T cnt = 4
        run_to(DIV + 4, "reset_seek");
        reset = 1'b1;
        tick("abort_rst");
        n_cmp++;
        assert (anodo === 2'b11 && escolha === 1'b0 && N === 8'h00) else begin
            n_err++; $error("FAIL abort_rst: got %b/%b/%h expected 11/0/00", anodo, escolha, N);
        end
        reset = 1'b0;
        tick("restart_rst");
        run(FRAME, "restart_rst_run");

        // Randomized run with invariants
        inv_on   = 1;
        prev_esc = escolha;
        for (int i = 0; i < 1000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            habilita   = ($urandom_range(0, 99) != 0);
            placar     = 8'($urandom);
            apaga_zero = 1'($urandom);
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
